// File: rtl/s_core_loader_pkg.sv
// s_core_loader_pkg
//   Shared definitions for the s_core setup/preload sequencer:
//   command opcodes, opcode field position within a command word,
//   and the sequencer state encoding.
package s_core_loader_pkg;

    // Opcode field of a command word: bits [31:28]; bits [27:0] are the argument.
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 28;

    localparam logic [3:0] OP_IMEM = 4'h1;  // burst write into instruction memory
    localparam logic [3:0] OP_REG  = 4'h2;  // single register preload
    localparam logic [3:0] OP_PC   = 4'h3;  // set core start PC
    localparam logic [3:0] OP_RUN  = 4'h4;  // release the core
    localparam logic [3:0] OP_HALT = 4'h5;  // return core to setup mode

    typedef enum logic [2:0] {
        ST_WAIT_CMD = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_BURST    = 3'd2,
        ST_GET_REG  = 3'd3,
        ST_GET_PC   = 3'd4
    } loader_state_t;

endpackage : s_core_loader_pkg

// File: rtl/s_core_loader.sv
// s_core_loader
//   Setup/preload sequencer for s_core. Consumes a 32-bit command stream
//   over a valid/ready handshake and turns it into instruction-memory
//   writes, register-file preloads and the start PC, then releases the
//   core by deasserting setup.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   s_valid / s_ready        command stream handshake (s_ready is always 1)
//   s_data                   command or payload word
//   inst_mem_addr/_data/_we  imem write port, one strobe per written word
//   load_reg_addr/_data/_we  register preload port
//   i_pc_instr_start_addr    core start PC
//   setup                    1 = core held in setup mode, 0 = running
//   busy                     loader is mid-command
//   err                      sticky protocol/range error
//   csum                     running burst checksum (only with LOADER_CSUM_EN)
//
// Optional feature macro: LOADER_CSUM_EN adds the csum output and its adder.
module s_core_loader
    import s_core_loader_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16,
    parameter int IMEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [ADDR_W-1:0] inst_mem_addr,
    output logic [DATA_W-1:0] inst_mem_data,
    output logic              inst_mem_we,
    output logic [REG_AW-1:0] load_reg_addr,
    output logic [DATA_W-1:0] load_reg_data,
    output logic              load_reg_we,
    output logic [ADDR_W-1:0] i_pc_instr_start_addr,
    output logic              setup,
`ifdef LOADER_CSUM_EN
    output logic [DATA_W-1:0] csum,
`endif
    output logic              busy,
    output logic              err
);

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
    logic [REG_AW-1:0] reg_idx_q, reg_idx_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_data_q, reg_data_d;
    logic              reg_we_q, reg_we_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              setup_q, setup_d;
    logic              err_q, err_d;
`ifdef LOADER_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] word_addr;
    logic              addr_in_range;

    assign opcode        = s_data[OP_MSB:OP_LSB];
    assign word_addr     = burst_addr_q >> 2;
    assign addr_in_range = word_addr < ADDR_W'(IMEM_DEPTH);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        burst_addr_d = burst_addr_q;
        reg_idx_d    = reg_idx_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = 1'b0;
        reg_addr_d   = reg_addr_q;
        reg_data_d   = reg_data_q;
        reg_we_d     = 1'b0;
        pc_d         = pc_q;
        setup_d      = setup_q;
        err_d        = err_q;
`ifdef LOADER_CSUM_EN
        csum_d       = csum_q;
`endif
        if (s_valid) begin
            unique case (state_q)
                ST_WAIT_CMD: begin
                    // Load commands are only honoured in setup mode; while the
                    // core runs they are flagged and their payload is left to
                    // be parsed as the next command.
                    if (opcode == OP_IMEM) begin
                        if (setup_q) begin
                            cnt_d   = s_data[CNT_W-1:0];
                            state_d = ST_GET_ADDR;
`ifdef LOADER_CSUM_EN
                            csum_d  = '0;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (opcode == OP_REG) begin
                        if (setup_q) begin
                            reg_idx_d = s_data[REG_AW-1:0];
                            state_d   = ST_GET_REG;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (opcode == OP_PC) begin
                        if (setup_q) begin
                            state_d = ST_GET_PC;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (opcode == OP_RUN) begin
                        setup_d = 1'b0;
                    end else if (opcode == OP_HALT) begin
                        setup_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_GET_ADDR: begin
                    burst_addr_d = s_data[ADDR_W-1:0];
                    // A zero-length burst is a legal no-op.
                    state_d = (cnt_q == '0) ? ST_WAIT_CMD : ST_BURST;
                end
                ST_BURST: begin
                    // Out-of-range words are dropped but still counted, so the
                    // stream stays aligned with the host's framing.
                    if (addr_in_range) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = burst_addr_q;
                        mem_data_d = s_data;
                    end else begin
                        err_d = 1'b1;
                    end
`ifdef LOADER_CSUM_EN
                    csum_d = csum_q + s_data;
`endif
                    burst_addr_d = burst_addr_q + ADDR_W'(4);
                    cnt_d        = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_WAIT_CMD;
                    end
                end
                ST_GET_REG: begin
                    // x0 is hardwired to zero in the core: swallow silently.
                    if (reg_idx_q != '0) begin
                        reg_we_d   = 1'b1;
                        reg_addr_d = reg_idx_q;
                        reg_data_d = s_data;
                    end
                    state_d = ST_WAIT_CMD;
                end
                ST_GET_PC: begin
                    pc_d    = s_data[ADDR_W-1:0];
                    state_d = ST_WAIT_CMD;
                end
                default: state_d = ST_WAIT_CMD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_WAIT_CMD;
            cnt_q        <= '0;
            burst_addr_q <= '0;
            reg_idx_q    <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_data_q   <= '0;
            reg_we_q     <= 1'b0;
            pc_q         <= '0;
            setup_q      <= 1'b1;
            err_q        <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            burst_addr_q <= burst_addr_d;
            reg_idx_q    <= reg_idx_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            reg_addr_q   <= reg_addr_d;
            reg_data_q   <= reg_data_d;
            reg_we_q     <= reg_we_d;
            pc_q         <= pc_d;
            setup_q      <= setup_d;
            err_q        <= err_d;
`ifdef LOADER_CSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // The loader never back-pressures the host.
    assign s_ready               = 1'b1;
    assign inst_mem_addr         = mem_addr_q;
    assign inst_mem_data         = mem_data_q;
    assign inst_mem_we           = mem_we_q;
    assign load_reg_addr         = reg_addr_q;
    assign load_reg_data         = reg_data_q;
    assign load_reg_we           = reg_we_q;
    assign i_pc_instr_start_addr = pc_q;
    assign setup                 = setup_q;
    assign busy                  = (state_q != ST_WAIT_CMD);
    assign err                   = err_q;
`ifdef LOADER_CSUM_EN
    assign csum                  = csum_q;
`endif

endmodule : s_core_loader

// File: tb/tb_s_core_loader.sv
// tb_s_core_loader
//   Directed self-checking bench for s_core_loader. The DUT is built with a
//   4-word instruction memory so the range check is reachable with short
//   bursts. Define LOADER_CSUM_EN to also exercise the checksum output.
module tb_s_core_loader;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [31:0] inst_mem_addr;
    logic [31:0] inst_mem_data;
    logic        inst_mem_we;
    logic [4:0]  load_reg_addr;
    logic [31:0] load_reg_data;
    logic        load_reg_we;
    logic [31:0] i_pc_instr_start_addr;
    logic        setup;
    logic        busy;
    logic        err;
`ifdef LOADER_CSUM_EN
    logic [31:0] csum;
`endif

    int tests;
    int fails;

    s_core_loader #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .REG_AW    (5),
        .CNT_W     (16),
        .IMEM_DEPTH(4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_valid              (s_valid),
        .s_ready              (s_ready),
        .s_data               (s_data),
        .inst_mem_addr        (inst_mem_addr),
        .inst_mem_data        (inst_mem_data),
        .inst_mem_we          (inst_mem_we),
        .load_reg_addr        (load_reg_addr),
        .load_reg_data        (load_reg_data),
        .load_reg_we          (load_reg_we),
        .i_pc_instr_start_addr(i_pc_instr_start_addr),
        .setup                (setup),
`ifdef LOADER_CSUM_EN
        .csum                 (csum),
`endif
        .busy                 (busy),
        .err                  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word on the negedge; return 1 time unit after the edge that
    // accepts it, when the registered response to that word is visible.
    // s_valid is left high so consecutive calls are back-to-back.
    task automatic send(input logic [31:0] w);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        @(posedge clk);
        #1;
        $display("[TB] word %08h accepted: we=%0b addr=%08h data=%08h rwe=%0b setup=%0b busy=%0b err=%0b",
                 w, inst_mem_we, inst_mem_addr, inst_mem_data, load_reg_we, setup, busy, err);
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'h0;
        #12;
        tests++;
        if ({setup, s_ready, busy, err} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_flags got setup/ready/busy/err=%04b want 1100", {setup, s_ready, busy, err});
        end
        tests++;
        if ({inst_mem_we, load_reg_we} !== 2'b00 || inst_mem_addr !== 32'h0 || i_pc_instr_start_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs got we=%0b rwe=%0b addr=%08h pc=%08h want all zero",
                     inst_mem_we, load_reg_we, inst_mem_addr, i_pc_instr_start_addr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_burst();
        send(32'h1000_0002);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL burst_busy got %0b want 1", busy); end
        send(32'h0000_0004);
        send(32'h0012_7413);
        tests++;
        if (inst_mem_we !== 1'b1 || inst_mem_addr !== 32'h4 || inst_mem_data !== 32'h0012_7413) begin
            fails++;
            $display("FAIL burst_w0 got we=%0b addr=%08h data=%08h want 1 00000004 00127413",
                     inst_mem_we, inst_mem_addr, inst_mem_data);
        end
        send(32'h0062_08B3);
        tests++;
        if (inst_mem_we !== 1'b1 || inst_mem_addr !== 32'h8 || inst_mem_data !== 32'h0062_08B3 || busy !== 1'b0) begin
            fails++;
            $display("FAIL burst_w1 got we=%0b addr=%08h data=%08h busy=%0b want 1 00000008 006208b3 0",
                     inst_mem_we, inst_mem_addr, inst_mem_data, busy);
        end
        idle();
        @(posedge clk);
        #1;
        tests++;
        if (inst_mem_we !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL burst_end got we=%0b err=%0b want 0 0", inst_mem_we, err);
        end
    endtask

    task automatic test_reg_preload();
        send(32'h2000_0004);
        send(32'h0000_0001);
        tests++;
        if (load_reg_we !== 1'b1 || load_reg_addr !== 5'd4 || load_reg_data !== 32'h1) begin
            fails++;
            $display("FAIL reg_wr got we=%0b idx=%0d data=%08h want 1 4 00000001",
                     load_reg_we, load_reg_addr, load_reg_data);
        end
        send(32'h2000_0000);
        tests++;
        if (load_reg_we !== 1'b0) begin fails++; $display("FAIL reg_single_pulse got %0b want 0", load_reg_we); end
        send(32'h0000_0005);
        tests++;
        if (load_reg_we !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reg_x0 got we=%0b err=%0b want 0 0", load_reg_we, err);
        end
        idle();
    endtask

    task automatic test_start();
        send(32'h3000_0000);
        send(32'h0000_0004);
        tests++;
        if (i_pc_instr_start_addr !== 32'h4 || setup !== 1'b1) begin
            fails++;
            $display("FAIL set_pc got pc=%08h setup=%0b want 00000004 1", i_pc_instr_start_addr, setup);
        end
        send(32'h4000_0000);
        tests++;
        if (setup !== 1'b0) begin fails++; $display("FAIL run got setup=%0b want 0", setup); end
        send(32'h4000_0000);
        tests++;
        if (setup !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL run_again got setup=%0b err=%0b want 0 0", setup, err);
        end
        send(32'h2000_0006);
        tests++;
        if (err !== 1'b1 || load_reg_we !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reg_while_running got err=%0b we=%0b busy=%0b want 1 0 0", err, load_reg_we, busy);
        end
        send(32'h5000_0000);
        tests++;
        if (setup !== 1'b1) begin fails++; $display("FAIL halt got setup=%0b want 1", setup); end
        idle();
    endtask

    task automatic test_range_wrap();
        do_reset();
        #1;
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL err_cleared got %0b want 0", err); end
        send(32'h1000_0003);
        send(32'h0000_0008);
        send(32'hAAAA_0001);
        tests++;
        if (inst_mem_we !== 1'b1 || inst_mem_addr !== 32'h8) begin
            fails++;
            $display("FAIL range_w0 got we=%0b addr=%08h want 1 00000008", inst_mem_we, inst_mem_addr);
        end
        send(32'hAAAA_0002);
        tests++;
        if (inst_mem_we !== 1'b1 || inst_mem_addr !== 32'hC || err !== 1'b0) begin
            fails++;
            $display("FAIL range_w1 got we=%0b addr=%08h err=%0b want 1 0000000c 0", inst_mem_we, inst_mem_addr, err);
        end
        send(32'hAAAA_0003);
        tests++;
        if (inst_mem_we !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL range_w2 got we=%0b err=%0b busy=%0b want 0 1 0", inst_mem_we, err, busy);
        end
        send(32'h1000_0002);
        send(32'hFFFF_FFFC);
        send(32'hBBBB_0001);
        tests++;
        if (inst_mem_we !== 1'b0) begin fails++; $display("FAIL wrap_w0 got we=%0b want 0", inst_mem_we); end
        send(32'hBBBB_0002);
        tests++;
        if (inst_mem_we !== 1'b1 || inst_mem_addr !== 32'h0 || inst_mem_data !== 32'hBBBB_0002) begin
            fails++;
            $display("FAIL wrap_w1 got we=%0b addr=%08h data=%08h want 1 00000000 bbbb0002",
                     inst_mem_we, inst_mem_addr, inst_mem_data);
        end
        idle();
    endtask

    task automatic test_bad_op_and_reset();
        do_reset();
        send(32'hF000_0000);
        tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bad_opcode got err=%0b busy=%0b want 1 0", err, busy);
        end
        // Reset mid-burst: strobe already high must drop without a clock edge.
        send(32'h1000_0004);
        send(32'h0000_0000);
        send(32'hCCCC_0001);
        #1 rst = 1'b1;
        #1;
        tests++;
        if (inst_mem_we !== 1'b0 || setup !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_burst got we=%0b setup=%0b busy=%0b err=%0b want 0 1 0 0",
                     inst_mem_we, setup, busy, err);
        end
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        // Async reset while running: setup must return to 1 before any edge.
        send(32'h4000_0000);
        idle();
        #1 rst = 1'b1;
        #1;
        tests++;
        if (setup !== 1'b1) begin fails++; $display("FAIL async_reset_setup got %0b want 1", setup); end
        @(negedge clk);
        rst = 1'b0;
        send(32'h1000_0001);
        send(32'h0000_0004);
        send(32'hDDDD_0001);
        tests++;
        if (inst_mem_we !== 1'b1 || inst_mem_addr !== 32'h4 || inst_mem_data !== 32'hDDDD_0001 || busy !== 1'b0) begin
            fails++;
            $display("FAIL burst_after_reset got we=%0b addr=%08h data=%08h busy=%0b want 1 00000004 dddd0001 0",
                     inst_mem_we, inst_mem_addr, inst_mem_data, busy);
        end
        idle();
    endtask

`ifdef LOADER_CSUM_EN
    task automatic test_csum();
        send(32'h1000_0003);
        tests++;
        if (csum !== 32'h0) begin fails++; $display("FAIL csum_clear got %08h want 00000000", csum); end
        send(32'h0000_0000);
        send(32'h0000_0001);
        send(32'h0000_0002);
        send(32'hFFFF_FFFF);
        tests++;
        if (csum !== 32'h0000_0002) begin fails++; $display("FAIL csum_sum got %08h want 00000002", csum); end
        idle();
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_burst();
        test_reg_preload();
        test_start();
        test_range_wrap();
        test_bad_op_and_reset();
`ifdef LOADER_CSUM_EN
        test_csum();
`endif
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net: the directed sequence is short, so anything this long is a hang.
    initial begin
        #200000;
        $display("FAIL timeout got no completion want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule : tb_s_core_loader

// File: doc/s_core_loader.md
Name: s_core_loader

Overview:
- Synthesizable setup/preload sequencer for s_core.
- Consumes a 32-bit command stream over a valid/ready handshake.
- Drives instruction-memory writes, register-file preloads and the start PC, then releases the core by deasserting setup.
- Replaces hand-driven bench setup; sits between a host/UART/debug bridge and s_core's setup ports.

Parameters:
DATA_W, 32, width of command/data words and memory data
ADDR_W, 32, instruction-memory byte address width
REG_AW, 5, register index width (32 registers)
CNT_W, 16, burst length field width
IMEM_DEPTH, 1024, instruction memory depth in words; bound for address check

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_valid  in  1  command/data word valid
s_ready  out  1  loader accepts word this cycle
s_data  in  DATA_W  command or payload word
inst_mem_addr  out  ADDR_W  imem write byte address
inst_mem_data  out  DATA_W  imem write data
inst_mem_we  out  1  imem write strobe, one cycle per word
load_reg_addr  out  REG_AW  register preload index
load_reg_data  out  DATA_W  register preload data
load_reg_we  out  1  register write strobe
i_pc_instr_start_addr  out  ADDR_W  core start PC
setup  out  1  1 = core held in setup/load mode, 0 = running
busy  out  1  loader mid-command (state != WAIT_CMD)
err  out  1  sticky protocol/range error

Behaviour:
- Clock is clk; reset is asynchronous, active-high.
- Reset values: setup=1, s_ready=1, all strobes 0, all address/data/PC outputs 0, busy=0, err=0, state=WAIT_CMD.
- A word is transferred when s_valid & s_ready. s_ready is 1 in every state; the loader never stalls. s_data is ignored when s_valid=0.
- Command word: [31:28] opcode, [27:0] arg.
  - 0x1 IMEM_BURST: N=arg[CNT_W-1:0]. Next word is the base byte address; then N data words.
  - 0x2 REG_WR: idx=arg[REG_AW-1:0]. Next word is the data.
  - 0x3 SET_PC: next word is the PC.
  - 0x4 RUN.
  - 0x5 HALT.
  - Any other opcode: set err, consume the word, stay in WAIT_CMD.
- States: WAIT_CMD, GET_ADDR, BURST, GET_REG, GET_PC.
  - WAIT_CMD -> GET_ADDR on opcode 0x1.
  - GET_ADDR -> BURST if N>0, else -> WAIT_CMD (N=0 is a legal no-op).
  - BURST: each accepted word is written. The address increments by 4 modulo 2^ADDR_W. Return to WAIT_CMD after the Nth word.
  - GET_REG and GET_PC return to WAIT_CMD after one word.
- Latency: write strobes and outputs are registered and assert the cycle after the word is accepted. Back-to-back words produce back-to-back strobes.
- Range check: a burst word whose word address (addr>>2) >= IMEM_DEPTH is not written (we stays 0) and sets err. The burst still counts the word and continues.
- REG_WR to idx 0: consumed, no strobe (x0 is hardwired), no error.
- RUN: setup<=0 the next cycle. RUN while already running is a no-op.
- HALT: setup<=1 the next cycle.
- While setup=0, opcodes 0x1/0x2/0x3 are consumed with no side effects and set err. Their payload words are not consumed: they are parsed as commands.
- err clears only on rst.
- Reset mid-burst: the partial burst is abandoned and setup returns to 1 asynchronously. Words already written remain in imem.

Optional Feature:
- LOADER_CSUM_EN defined:
  - Adds output csum (DATA_W). It is a running 32-bit wrapping sum of every accepted burst data word, including out-of-range words.
  - Cleared to 0 when an IMEM_BURST command is accepted, and on rst.
  - Updates the same cycle inst_mem_we would.
- Undefined: no csum port, no adder.

Decomposition:
- Package s_core_loader_pkg holds:
  - opcode constants (OP_IMEM=4'h1, OP_REG=4'h2, OP_PC=4'h3, OP_RUN=4'h4, OP_HALT=4'h5);
  - state encoding;
  - opcode field positions [31:28].
- No sub-module is needed; a single FSM plus datapath registers is sufficient.

Test Plan:
- Burst: 0x10000002, 0x00000004, 0x00127413, 0x006208B3 -> inst_mem_we pulses two consecutive cycles, addr 0x4 then 0x8 with those data; busy falls after the second word; err=0.
- Register preload: 0x20000004, 0x00000001 then 0x20000000, 0x5 -> one load_reg_we with addr 4, data 1; no strobe for idx 0.
- Start: 0x30000000, 0x00000004, then 0x40000000 -> i_pc_instr_start_addr=0x4; setup falls one cycle after RUN is accepted. A following 0x20000006 sets err with no strobe; then 0x50000000 -> setup=1.
- Range/wrap: IMEM_DEPTH=4, burst N=3 at base 0x8 -> writes at 0x8 and 0xC, third word (0x10) suppressed, err=1. Burst at base 0xFFFFFFFC, N=2 -> second address is 0x0 (range-checked).
- Bad opcode and reset: 0xF0000000 -> err=1, state WAIT_CMD. rst asserted mid-burst -> setup=1 and strobes 0 immediately; the next burst starts cleanly.
- With LOADER_CSUM_EN: burst of 0x1, 0x2, 0xFFFFFFFF -> csum=0x00000002.
